ramz_reader: RTL and testbench
==============================

RAMZ_READER -- requirements
Module: ramz_reader

Interface
REQ-001 Parameter RD_LAT, default 1; ramz read latency in cycles from rd_addr to rd_data, fixed 1.
REQ-002 clk  input  1  single clock; all ramz read-port traffic uses this clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a burst; ignored while busy=1.
REQ-005 base  input  7  first ramz word address, sampled when start is accepted.
REQ-006 len_m1  input  7  burst length minus one (0 gives 1 word, 127 gives 128 words), sampled with base.
REQ-007 rd_addr  output  7  ramz read address (addrb).
REQ-008 rd_data  input  32  ramz read data (doutb), valid RD_LAT cycles after rd_addr.
REQ-009 m_data  output  32  streamed word.
REQ-010 m_valid  output  1  m_data valid.
REQ-011 m_last  output  1  marks the final word of the burst, qualified by m_valid.
REQ-012 m_ready  input  1  downstream accept; a transfer occurs when m_valid and m_ready are both 1.
REQ-013 busy  output  1  burst in progress, from start acceptance until the last word transfers.
REQ-014 done  output  1  one-cycle pulse in the cycle after the last transfer.

Function
REQ-015 States IDLE, RUN, DRAIN; IDLE->RUN on start; RUN->DRAIN after the last address issues; DRAIN->IDLE on the m_last transfer.
REQ-016 Start acceptance: in IDLE, start=1 latches base and len_m1 and sets busy=1 in the next cycle.
REQ-017 Addresses issue in order base, base+1, ... modulo 128; base+len_m1 past 127 wraps to 0.
REQ-018 An address issues only if the skid buffer has room for all in-flight reads plus the new read, so no read data is ever dropped.
REQ-019 Skid buffer depth is 2 words; sustained throughput is 1 word per cycle while m_ready=1.
REQ-020 First-word latency: m_valid rises no later than the 3rd cycle after the start is accepted.
REQ-021 Once m_valid=1, m_data and m_last hold stable until the transfer occurs.
REQ-022 m_last=1 only on word number len_m1+1 of the burst.
REQ-023 rd_addr holds its last value while no read issues.
REQ-024 A start in the same cycle as done is ignored; a new burst requires start while busy=0.
REQ-025 The word count is 8 bits wide internally so that a 128-word burst counts without overflow.

Reset
REQ-026 rst=1 forces state IDLE and sets busy=0, done=0, m_valid=0, m_last=0, rd_addr=0, m_data=0 and the buffer to empty, immediately and regardless of clk.
REQ-027 Reset during a burst abandons the burst: no done pulse, and in-flight read data is discarded.
REQ-028 After rst deasserts, the first accepted start behaves identically to a start after power-up.

Structure
REQ-029 Package ramz_pkg holds RAMZ_AW=7, RAMZ_DW=32, RAMZ_DEPTH=128 and the state enumeration.
REQ-030 The 2-entry buffer is a sub-module, ramz_skid, with valid/ready on both sides and an occupancy output.
REQ-031 ramz_reader connects directly to the ramz read port and contains no storage arrays beyond ramz_skid.

Verification
REQ-032 RAM preloaded with word i = 0xA5000000+i; base=0, len_m1=3, m_ready=1 -> words 0xA5000000..0xA5000003 on 4 consecutive cycles, m_last on the 4th, done one cycle later.
REQ-033 base=126, len_m1=3 -> rd_addr sequence 126,127,0,1; data 0xA500007E,0xA500007F,0xA5000000,0xA5000001.
REQ-034 base=0, len_m1=127, m_ready randomly toggled at 50% -> exactly 128 transfers in order, no duplicates or drops, a single m_last.
REQ-035 base=5, len_m1=0 -> a single word 0xA5000005 with m_valid and m_last high together; start asserted while busy=1 is ignored.
REQ-036 rst asserted mid-burst after 10 of 64 words -> all outputs at reset values with no clk edge; a later burst with base=20, len_m1=1 returns 0xA5000014 and 0xA5000015.
REQ-037 m_ready held 0 for 20 cycles mid-burst -> m_data stable, skid occupancy at most 2, streaming resumes without a gap once m_ready=1.

Source files
------------

// File: rtl/ramz_pkg.sv
// Shared constants and the reader state enumeration for the ramz read path.
package ramz_pkg;

   localparam int RAMZ_AW    = 7;
   localparam int RAMZ_DW    = 32;
   localparam int RAMZ_DEPTH = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } ramz_state_e;

endpackage

// File: rtl/ramz_skid.sv
// Two-entry skid buffer. Entry 0 always holds the head word, so the output
// data is a plain register that stays put until it is accepted.
// Handshake: a word moves across a side only in a cycle where that side's
// valid and ready are both 1. Valid never waits on ready, and data stays
// stable while valid=1 and ready=0.
module ramz_skid #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic [1:0]   occ
);

   logic [W-1:0] d0_q, d0_d, d1_q, d1_d;
   logic [1:0]   occ_q, occ_d;
   logic         push, pop;

   // Handshakes and the next contents of the two entries.
   always_comb begin
      out_valid = (occ_q != 2'd0);
      in_ready  = (occ_q != 2'd2) || out_ready;
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
      d0_d      = d0_q;
      d1_d      = d1_q;
      occ_d     = occ_q;
      case ({push, pop})
         2'b10: begin
            if (occ_q == 2'd0) d0_d = in_data;
            else               d1_d = in_data;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            d0_d  = d1_q;
            occ_d = occ_q - 2'd1;
         end
         2'b11: begin
            if (occ_q == 2'd1) begin
               d0_d = in_data;
            end else begin
               d0_d = d1_q;
               d1_d = in_data;
            end
         end
         default: ;
      endcase
   end

   // Storage registers; reset empties the buffer and clears the head word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d0_q  <= '0;
         d1_q  <= '0;
         occ_q <= 2'd0;
      end else begin
         d0_q  <= d0_d;
         d1_q  <= d1_d;
         occ_q <= occ_d;
      end
   end

   assign out_data = d0_q;
   assign occ      = occ_q;

endmodule

// File: rtl/ramz_reader.sv
// Burst reader: walks a block of ramz addresses and streams the read data
// out through a 2-entry skid buffer with valid/ready flow control.
// A read issues only when the buffer is sure to have room for it on return,
// counting words still in the RAM pipeline and any word leaving this cycle.
module ramz_reader
   import ramz_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [RAMZ_AW-1:0] base,
   input  logic [RAMZ_AW-1:0] len_m1,
   output logic [RAMZ_AW-1:0] rd_addr,
   input  logic [RAMZ_DW-1:0] rd_data,
   output logic [RAMZ_DW-1:0] m_data,
   output logic               m_valid,
   output logic               m_last,
   input  logic               m_ready,
   output logic               busy,
   output logic               done,
   output ramz_state_e        dbg_state,
   output logic [1:0]         dbg_occ
);

   ramz_state_e       state_q, state_d;
   logic [RAMZ_AW-1:0] next_addr_q, next_addr_d;
   logic [RAMZ_AW-1:0] last_addr_q, last_addr_d;
   logic [RAMZ_AW-1:0] len_q, len_d;
   logic [7:0]         issue_cnt_q, issue_cnt_d;
   logic               done_q, done_d;
   logic [3:0]         infl_q, infl_d;
   logic [RD_LAT-1:0]  pipe_v_q, pipe_v_d;
   logic [RD_LAT-1:0]  pipe_l_q, pipe_l_d;

   logic               sk_in_ready, sk_out_valid;
   logic [RAMZ_DW:0]   sk_out_data;
   logic [1:0]         occ;
   logic               pop, room, issue, last_issue, arrive;

   // Read issue decision and tracking of reads still inside the RAM.
   always_comb begin
      pop        = sk_out_valid && m_ready;
      room       = ({2'b00, occ} + infl_q + 4'd1) <= (4'd2 + {3'b000, pop});
      issue      = (state_q == RUN) && room && sk_in_ready;
      last_issue = issue && (issue_cnt_q == {1'b0, len_q});
      arrive     = pipe_v_q[RD_LAT-1];
      infl_d     = infl_q + {3'b000, issue} - {3'b000, arrive};
      pipe_v_d   = pipe_v_q;
      pipe_l_d   = pipe_l_q;
      pipe_v_d[0] = issue;
      pipe_l_d[0] = last_issue;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_v_d[i] = pipe_v_q[i-1];
         pipe_l_d[i] = pipe_l_q[i-1];
      end
   end

   // Next-state logic: burst setup, address walk, end-of-burst detection.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      next_addr_d = next_addr_q;
      last_addr_d = last_addr_q;
      issue_cnt_d = issue_cnt_q;
      done_d      = 1'b0;
      if (issue) begin
         next_addr_d = next_addr_q + 7'd1;
         last_addr_d = next_addr_q;
         issue_cnt_d = issue_cnt_q + 8'd1;
      end
      case (state_q)
         IDLE: begin
            // The done cycle still refuses a start so bursts never overlap.
            if (start && !done_q) begin
               len_d       = len_m1;
               next_addr_d = base;
               issue_cnt_d = 8'd0;
               state_d     = RUN;
            end
         end
         RUN: begin
            if (last_issue) state_d = DRAIN;
         end
         DRAIN: begin
            if (pop && sk_out_data[RAMZ_DW]) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and burst registers; reset abandons any burst in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         len_q       <= '0;
         next_addr_q <= '0;
         last_addr_q <= '0;
         issue_cnt_q <= 8'd0;
         done_q      <= 1'b0;
         infl_q      <= 4'd0;
         pipe_v_q    <= '0;
         pipe_l_q    <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         next_addr_q <= next_addr_d;
         last_addr_q <= last_addr_d;
         issue_cnt_q <= issue_cnt_d;
         done_q      <= done_d;
         infl_q      <= infl_d;
         pipe_v_q    <= pipe_v_d;
         pipe_l_q    <= pipe_l_d;
      end
   end

   ramz_skid #(.W(RAMZ_DW + 1)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (arrive),
      .in_ready  (sk_in_ready),
      .in_data   ({pipe_l_q[RD_LAT-1], rd_data}),
      .out_valid (sk_out_valid),
      .out_ready (m_ready),
      .out_data  (sk_out_data),
      .occ       (occ)
   );

   // The address only moves on an issue, otherwise it shows the last one read.
   assign rd_addr   = issue ? next_addr_q : last_addr_q;
   assign m_valid   = sk_out_valid;
   assign m_data    = sk_out_data[RAMZ_DW-1:0];
   assign m_last    = sk_out_valid && sk_out_data[RAMZ_DW];
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign dbg_state = state_q;
   assign dbg_occ   = occ;

endmodule

// File: tb/tb_ramz_reader.sv
// Bench for ramz_reader: RAM model preloaded with 0xA5000000+i, expected
// words queued at burst start and popped on each observed transfer.
module tb_ramz_reader;
  import ramz_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  base = '0;
  logic [6:0]  len_m1 = '0;
  logic [6:0]  rd_addr;
  logic [31:0] rd_data = '0;
  logic [31:0] m_data;
  logic        m_valid, m_last, busy, done;
  logic        m_ready = 1'b0;
  ramz_state_e dbg_state;
  logic [1:0]  dbg_occ;

  logic [31:0] mem [RAMZ_DEPTH];
  logic [32:0] exp_q[$];
  logic [6:0]  addr_log[$];
  int          vectors = 0;
  int          miscompares = 0;

  ramz_reader #(.RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len_m1(len_m1),
    .rd_addr(rd_addr), .rd_data(rd_data), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_ready(m_ready), .busy(busy), .done(done),
    .dbg_state(dbg_state), .dbg_occ(dbg_occ)
  );

  // clock and RAM read port model
  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr];

  // Runs one burst from the current cycle. Caller sits just after a posedge.
  task automatic drive_burst(input logic [6:0] b, input logic [6:0] l,
                             input int ready_pct, input int stall_from,
                             input int abort_after, input bit poke,
                             output int nxfer);
    logic [32:0] exp_w, got_w, prev_w;
    logic [6:0]  a, prev_addr;
    logic        prev_stall, got_last;
    int          first_valid;
    bit          fin;
    nxfer = 0; got_last = 0; first_valid = -1; prev_stall = 0; fin = 0;
    prev_w = '0; prev_addr = rd_addr;
    for (int i = 0; i <= int'(l); i++) begin
      a = b + 7'(i);
      exp_q.push_back({(i == int'(l)), 32'hA5000000 + {25'd0, a}});
    end
    start = 1'b1; base = b; len_m1 = l;
    for (int cyc = 1; cyc <= 3000 && !fin; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0; base = 7'd99; len_m1 = 7'd5;
      if (poke && cyc == 2) start = 1'b1;
      if (stall_from > 0 && cyc >= stall_from && cyc < stall_from + 20) m_ready = 1'b0;
      else m_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      if (cyc == 1) begin
        vectors++;
        if (busy !== 1'b1 || dbg_state !== RUN) begin
          miscompares++;
          $display("FAIL accept: busy=%b state=%0d, required busy=1 state=RUN", busy, dbg_state);
        end
      end
      vectors++;
      if (got_last) begin
        fin = 1;
        if (done !== 1'b1 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL done_pulse: done=%b busy=%b, required done=1 busy=0", done, busy);
        end
      end else if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL early_done: done=%b at cycle %0d, required 0", done, cyc);
      end
      if (prev_stall) begin
        vectors++;
        if (m_valid !== 1'b1 || {m_last, m_data} !== prev_w) begin
          miscompares++;
          $display("FAIL hold: valid=%b word=%h, required valid=1 word=%h", m_valid, {m_last, m_data}, prev_w);
        end
      end
      if (!m_ready) begin
        vectors++;
        if (dbg_occ > 2'd2) begin
          miscompares++;
          $display("FAIL occupancy: %0d, required at most 2", dbg_occ);
        end
      end
      if (ready_pct == 100 && first_valid >= 0 && m_ready && !got_last) begin
        vectors++;
        if (m_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL gap: m_valid=%b at cycle %0d, required 1", m_valid, cyc);
        end
      end
      if (m_valid && first_valid < 0) begin
        first_valid = cyc;
        vectors++;
        if (cyc > 3) begin
          miscompares++;
          $display("FAIL latency: first valid at cycle %0d, required <= 3", cyc);
        end
      end
      if (m_valid && m_ready) begin
        got_w = {m_last, m_data};
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL extra_word: got %h, required no transfer", got_w);
        end else begin
          exp_w = exp_q.pop_front();
          if (got_w !== exp_w) begin
            miscompares++;
            $display("FAIL word %0d: got %h, required %h", nxfer, got_w, exp_w);
          end
        end
        nxfer++;
        if (m_last) got_last = 1'b1;
        if (abort_after > 0 && nxfer == abort_after) fin = 1;
      end
      prev_stall = m_valid && !m_ready;
      prev_w = {m_last, m_data};
      if (rd_addr !== prev_addr) begin
        addr_log.push_back(rd_addr);
        prev_addr = rd_addr;
      end
    end
    if (!fin) begin
      vectors++; miscompares++;
      $display("FAIL timeout: burst base=%0d len_m1=%0d did not finish, %0d words seen", b, l, nxfer);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 ||
        rd_addr !== 7'd0 || m_data !== 32'd0 || dbg_state !== IDLE || dbg_occ !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_values: busy=%b done=%b valid=%b last=%b addr=%0d data=%h occ=%0d, required all zero",
               busy, done, m_valid, m_last, rd_addr, m_data, dbg_occ);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int n;
    @(posedge clk); #1;
    drive_burst(7'd0, 7'd3, 100, 0, 0, 1'b0, n);
    vectors++;
    if (n != 4 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL basic_count: %0d words, %0d left, required 4 and 0", n, exp_q.size());
    end
    start = 1'b1; base = 7'd40; len_m1 = 7'd2;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_on_done: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_wrap();
    int n;
    logic [6:0] want [4];
    @(posedge clk); #1;
    addr_log.delete();
    want[0] = 7'd126; want[1] = 7'd127; want[2] = 7'd0; want[3] = 7'd1;
    drive_burst(7'd126, 7'd3, 100, 0, 0, 1'b0, n);
    vectors++;
    if (addr_log.size() != 4) begin
      miscompares++;
      $display("FAIL wrap_addr_count: %0d addresses, required 4", addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (addr_log[i] !== want[i]) begin
          miscompares++;
          $display("FAIL wrap_addr %0d: got %0d, required %0d", i, addr_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_single();
    int n;
    @(posedge clk); #1;
    drive_burst(7'd5, 7'd0, 100, 0, 0, 1'b1, n);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || m_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_start_ignored: busy=%b valid=%b, required 0 0", busy, m_valid);
      end
    end
    vectors++;
    if (n != 1 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL single_count: %0d words, required 1", n);
    end
  endtask

  task automatic test_random();
    int n;
    @(posedge clk); #1;
    drive_burst(7'd0, 7'd127, 50, 0, 0, 1'b0, n);
    vectors++;
    if (n != 128 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL random_count: %0d words, %0d left, required 128 and 0", n, exp_q.size());
    end
  endtask

  task automatic test_stall();
    int n;
    @(posedge clk); #1;
    drive_burst(7'd0, 7'd63, 100, 10, 0, 1'b0, n);
    vectors++;
    if (n != 64 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stall_count: %0d words, required 64", n);
    end
  endtask

  task automatic test_abort();
    int n;
    @(posedge clk); #1;
    drive_burst(7'd0, 7'd63, 100, 0, 10, 1'b0, n);
    rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 ||
        rd_addr !== 7'd0 || m_data !== 32'd0 || dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b done=%b valid=%b last=%b addr=%0d data=%h, required all zero",
               busy, done, m_valid, m_last, rd_addr, m_data);
    end
    exp_q.delete();
    m_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL post_reset_quiet: done=%b valid=%b busy=%b, required 0 0 0", done, m_valid, busy);
      end
    end
    drive_burst(7'd20, 7'd1, 100, 0, 0, 1'b0, n);
    vectors++;
    if (n != 2 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL after_reset_count: %0d words, required 2", n);
    end
  endtask

  initial begin
    for (int i = 0; i < RAMZ_DEPTH; i++) mem[i] = 32'hA5000000 + i;
    test_reset();
    test_basic();
    test_wrap();
    test_single();
    test_random();
    test_stall();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
